// File: rtl/AHB_package.sv
// Shared AHB types and encodings for the slave-side response path.
package AHB_package;

  localparam int AHB_DATA_W = 32;

  typedef struct packed {
    logic [AHB_DATA_W-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;
  } ahb_slv_resp_t;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  function automatic logic is_active(input logic [1:0] trans);
    return (trans == NONSEQ) || (trans == SEQ);
  endfunction

endpackage

// File: rtl/ahb_si_resp_mux_dp_default_slave.sv
// Built-in default slave: two-cycle ERROR sequencing, decode-error pulse and
// saturating decode-error counter.
//
// state   | meaning
// DS_IDLE | no error pending; accepts address phases
// DS_ERR1 | first ERROR cycle, HREADY low
// DS_ERR2 | second ERROR cycle, HREADY high; accepts like DS_IDLE
module ahb_default_slave
  import AHB_package::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             i_accept,
  input  logic             i_invalid,
  output ds_state_e        o_state,
  output logic             o_dec_err,
  output logic [CNT_W-1:0] o_err_cnt
);

  ds_state_e        r_state;
  logic             r_dec_err;
  logic [CNT_W-1:0] r_err_cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state   <= DS_IDLE;
      r_dec_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_dec_err <= 1'b0;
      case (r_state)
        DS_ERR1: r_state <= DS_ERR2;
        default: begin
          if (i_accept) begin
            if (i_invalid) begin
              r_state   <= DS_ERR1;
              r_dec_err <= 1'b1;
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end else begin
              r_state <= DS_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_dec_err = r_dec_err;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: rtl/ahb_si_resp_mux_dp.sv
// AHB slave-side response mux: registers the address-phase slave select and
// routes the selected slave (or the default slave) back in the data phase.
module ahb_si_resp_mux_dp
  import AHB_package::*;
#(
  parameter int CHANNEL_NUM = 7,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 8
) (
  input  logic                                HCLK,
  input  logic                                HRESETn,
  input  logic [CHANNEL_NUM-1:0]              hsel,
  input  logic [1:0]                          htrans,
  input  logic                                hready_in,
  input  logic [CHANNEL_NUM-1:0][DATA_W+1:0]  payload_in,
  output logic [DATA_W-1:0]                   hrdata_out,
  output logic                                hready_out,
  output logic                                hresp_out,
  output logic                                dec_err,
  output logic [CNT_W-1:0]                    err_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] hrdata;
    logic              hreadyout;
    logic              hresp;
  } resp_t;

  logic [CHANNEL_NUM-1:0] r_dsel;
  logic                   w_onehot;
  logic                   w_active;
  logic                   w_invalid;
  ds_state_e              w_ds_state;
  resp_t                  w_sel;
  resp_t                  w_resp;

  assign w_onehot  = (hsel != '0) &&
                     ((hsel & (hsel - CHANNEL_NUM'(1))) == '0);
  assign w_active  = is_active(htrans);
  assign w_invalid = w_active && !w_onehot;

  // Only a valid one-hot active select is ever stored, so r_dsel is 0 or one-hot.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dsel <= '0;
    end else if (hready_in) begin
      r_dsel <= (w_active && w_onehot) ? hsel : '0;
    end
  end

  ahb_default_slave #(
    .CNT_W (CNT_W)
  ) u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .i_accept  (hready_in),
    .i_invalid (w_invalid),
    .o_state   (w_ds_state),
    .o_dec_err (dec_err),
    .o_err_cnt (err_cnt)
  );

  // AND-OR mux is exact because r_dsel is never multi-hot.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (r_dsel[i]) w_sel = w_sel | resp_t'(payload_in[i]);
    end
  end

  always_comb begin
    w_resp = '{hrdata: '0, hreadyout: 1'b1, hresp: HRESP_OKAY};
    if (w_ds_state == DS_ERR1) begin
      w_resp.hreadyout = 1'b0;
      w_resp.hresp     = HRESP_ERROR;
    end else if (w_ds_state == DS_ERR2) begin
      w_resp.hresp     = HRESP_ERROR;
    end else if (r_dsel != '0) begin
      w_resp = w_sel;
    end
  end

  assign hrdata_out = w_resp.hrdata;
  assign hready_out = w_resp.hreadyout;
  assign hresp_out  = w_resp.hresp;

endmodule

// File: tb/tb_ahb_si_resp_mux_dp.sv
// Directed bench for ahb_si_resp_mux_dp; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_ahb_si_resp_mux_dp;
  import AHB_package::*;

  localparam int CH = 7;
  localparam int DW = 32;

  logic                    HCLK = 1'b0;
  logic                    HRESETn;
  logic [CH-1:0]           hsel;
  logic [1:0]              htrans;
  logic                    hready_in;
  logic [CH-1:0][DW+1:0]   payload_in;

  logic [DW-1:0] hrdata_a, hrdata_b;
  logic          hready_a, hready_b;
  logic          hresp_a, hresp_b;
  logic          dec_a, dec_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;

  int n_cmp  = 0;
  int n_fail = 0;

  ahb_si_resp_mux_dp #(.CHANNEL_NUM(CH), .DATA_W(DW), .CNT_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .hsel(hsel), .htrans(htrans),
    .hready_in(hready_in), .payload_in(payload_in),
    .hrdata_out(hrdata_a), .hready_out(hready_a), .hresp_out(hresp_a),
    .dec_err(dec_a), .err_cnt(cnt_a)
  );

  ahb_si_resp_mux_dp #(.CHANNEL_NUM(CH), .DATA_W(DW), .CNT_W(2)) dut_c2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .hsel(hsel), .htrans(htrans),
    .hready_in(hready_in), .payload_in(payload_in),
    .hrdata_out(hrdata_b), .hready_out(hready_b), .hresp_out(hresp_b),
    .dec_err(dec_b), .err_cnt(cnt_b)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_dp(input string tag, input logic [31:0] d, input logic r, input logic s);
    check({tag, ".hrdata"}, 64'(hrdata_a), 64'(d));
    check({tag, ".hready"}, 64'(hready_a), 64'(r));
    check({tag, ".hresp"},  64'(hresp_a),  64'(s));
    check({tag, ".hready_c2"}, 64'(hready_b), 64'(r));
    check({tag, ".hresp_c2"},  64'(hresp_b),  64'(s));
  endtask

  task automatic chk_err(input string tag, input logic dec, input logic [7:0] ca, input logic [1:0] cb);
    check({tag, ".dec_err"},   64'(dec_a), 64'(dec));
    check({tag, ".dec_err_c2"},64'(dec_b), 64'(dec));
    check({tag, ".err_cnt"},   64'(cnt_a), 64'(ca));
    check({tag, ".err_cnt_c2"},64'(cnt_b), 64'(cb));
  endtask

  initial begin
    HRESETn    = 1'b0;
    hsel       = '0;
    htrans     = IDLE;
    hready_in  = 1'b1;
    payload_in = '0;
    #2;
    chk_dp("reset", 32'h0, 1'b1, 1'b0);
    chk_err("reset", 1'b0, 8'd0, 2'd0);
    tick;
    tick;
    HRESETn = 1'b1;

    // 1: basic read from slave 2
    payload_in[2] = {32'hDEADBEEF, 1'b1, 1'b0};
    hsel   = 7'b0000100;
    htrans = NONSEQ;
    #1;
    chk_dp("t1_pre", 32'h0, 1'b1, 1'b0);
    tick;
    chk_dp("t1_data", 32'hDEADBEEF, 1'b1, 1'b0);

    // 2: slave 2 waits 3 cycles while the next address phase targets slave 5
    payload_in[2] = {32'h2222_0001, 1'b0, 1'b0};
    payload_in[5] = {32'h5555_5555, 1'b1, 1'b0};
    hready_in = 1'b0;
    hsel      = 7'b0100000;
    htrans    = NONSEQ;
    for (int w = 0; w < 3; w++) begin
      #1;
      chk_dp($sformatf("t2_wait%0d", w), 32'h2222_0001, 1'b0, 1'b0);
      tick;
    end
    payload_in[2][1] = 1'b1;
    hready_in = 1'b1;
    #1;
    chk_dp("t2_release", 32'h2222_0001, 1'b1, 1'b0);
    tick;
    chk_dp("t2_slave5", 32'h5555_5555, 1'b1, 1'b0);

    // 3: unmapped select
    hsel   = '0;
    htrans = NONSEQ;
    tick;
    chk_dp("t3_err1", 32'h0, 1'b0, 1'b1);
    chk_err("t3_err1", 1'b1, 8'd1, 2'd1);
    hready_in = 1'b0;
    htrans    = IDLE;
    tick;
    chk_dp("t3_err2", 32'h0, 1'b1, 1'b1);
    chk_err("t3_err2", 1'b0, 8'd1, 2'd1);

    // 4: multi-hot select, back-to-back from DS_ERR2
    payload_in[3] = {32'h3333_3333, 1'b1, 1'b0};
    payload_in[4] = {32'h4444_4444, 1'b1, 1'b0};
    hready_in = 1'b1;
    hsel      = 7'b0011000;
    htrans    = SEQ;
    tick;
    chk_dp("t4_err1", 32'h0, 1'b0, 1'b1);
    chk_err("t4_err1", 1'b1, 8'd2, 2'd2);
    hready_in = 1'b0;
    hsel      = '0;
    htrans    = IDLE;
    tick;
    chk_dp("t4_err2", 32'h0, 1'b1, 1'b1);
    chk_err("t4_err2", 1'b0, 8'd2, 2'd2);

    // 5: inactive transfers are not errors and never forward a slave
    hready_in = 1'b1;
    hsel      = '0;
    htrans    = IDLE;
    tick;
    chk_dp("t5_idle", 32'h0, 1'b1, 1'b0);
    chk_err("t5_idle", 1'b0, 8'd2, 2'd2);
    hsel   = 7'b0001000;
    htrans = BUSY;
    tick;
    chk_dp("t5_busy", 32'h0, 1'b1, 1'b0);
    chk_err("t5_busy", 1'b0, 8'd2, 2'd2);

    // 6: five back-to-back errors; CNT_W=2 instance saturates
    for (int k = 0; k < 5; k++) begin
      hready_in = 1'b1;
      hsel      = '0;
      htrans    = NONSEQ;
      tick;
      chk_dp($sformatf("t6_err1_%0d", k), 32'h0, 1'b0, 1'b1);
      chk_err($sformatf("t6_err1_%0d", k), 1'b1, 8'(3 + k), 2'd3);
      hready_in = 1'b0;
      tick;
      chk_dp($sformatf("t6_err2_%0d", k), 32'h0, 1'b1, 1'b1);
    end

    // reset asserted during DS_ERR1
    hready_in = 1'b1;
    hsel      = '0;
    htrans    = NONSEQ;
    tick;
    chk_dp("t6_pre_rst", 32'h0, 1'b0, 1'b1);
    chk_err("t6_pre_rst", 1'b1, 8'd8, 2'd3);
    #2;
    HRESETn = 1'b0;
    #1;
    chk_dp("t6_rst", 32'h0, 1'b1, 1'b0);
    chk_err("t6_rst", 1'b0, 8'd0, 2'd0);
    htrans = IDLE;
    tick;
    chk_dp("t6_rst_hold", 32'h0, 1'b1, 1'b0);
    HRESETn = 1'b1;
    tick;
    chk_dp("t6_post_rst", 32'h0, 1'b1, 1'b0);
    chk_err("t6_post_rst", 1'b0, 8'd0, 2'd0);
    hsel   = 7'b0000100;
    htrans = NONSEQ;
    tick;
    chk_dp("t6_recover", 32'h2222_0001, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_si_resp_mux_dp.md
Name: ahb_si_resp_mux_dp

Overview:
Slave-side response multiplexer for the generated AHB interconnect, parametrised in channel count and data width.
- Registers the address-phase one-hot slave select.
- Routes the matching slave's HRDATA/HREADYOUT/HRESP back to the master in the data phase, with the correct AHB pipeline offset.
- Contains a built-in default slave that gives the two-cycle ERROR response for unmapped or multi-hot selects.
- Keeps a saturating decode-error counter.

Parameters:
- CHANNEL_NUM, 7, number of slave channels.
- DATA_W, 32, HRDATA width; payload per channel is DATA_W+2 bits.
- CNT_W, 8, width of the decode-error counter.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- hsel  in  CHANNEL_NUM  address-phase one-hot slave select from the decoder.
- htrans  in  2  address-phase HTRANS from the granted master.
- hready_in  in  1  bus HREADY (this block's hready_out looped back by the fabric).
- payload_in  in  CHANNEL_NUM x (DATA_W+2)  per-slave {hrdata, hreadyout, hresp}.
- hrdata_out  out  DATA_W  data-phase read data to the master.
- hready_out  out  1  data-phase HREADY to the master.
- hresp_out  out  1  data-phase HRESP (0=OKAY, 1=ERROR).
- dec_err  out  1  one-cycle pulse when an invalid address phase is accepted.
- err_cnt  out  CNT_W  saturating count of accepted decode errors.

Behaviour:
- Reset (async, HRESETn=0): dsel=0, ds_state=DS_IDLE, err_cnt=0, dec_err=0. Outputs are combinational from this state: hready_out=1, hresp_out=0, hrdata_out=0.
- Address phase is accepted on a rising HCLK only when hready_in=1. No state changes when hready_in=0, except the DS_ERR1->DS_ERR2 step.
- On accept, active transfer (htrans[1]=1, NONSEQ/SEQ):
  - hsel one-hot: dsel<=hsel, ds_state<=DS_IDLE.
  - hsel zero or multi-hot: dsel<=0, ds_state<=DS_ERR1, dec_err=1 in the following cycle, err_cnt+1 (saturates at all-ones, no wrap).
- On accept, inactive transfer (IDLE/BUSY): dsel<=0, ds_state<=DS_IDLE, regardless of hsel.
- Data-phase output mux (combinational on registered state):
  - dsel one-hot: outputs = payload_in[index of dsel].
  - dsel=0, DS_IDLE: hrdata=0, hready=1, hresp=0 (zero-wait OKAY).
  - DS_ERR1: hrdata=0, hready=0, hresp=1.
  - DS_ERR2: hrdata=0, hready=1, hresp=1.
- Default-slave FSM:
  - DS_IDLE -> DS_ERR1 on an invalid accept.
  - DS_ERR1 -> DS_ERR2 unconditionally next cycle.
  - DS_ERR2 behaves like DS_IDLE for acceptance. hready_in=1 there, so a new address phase is sampled and can go straight back to DS_ERR1 (back-to-back errors).
- Slave wait states: while the selected slave drives hreadyout=0, dsel holds because hready_in=0. The mux forwards the wait unchanged.
- Latency: response is muxed combinationally in the data phase, one clock after address-phase acceptance. No added pipeline stage.
- Reset asserted mid-transfer: all state clears immediately and outputs go to zero-wait OKAY. No partial error response is completed.
- dec_err is registered, high for exactly one cycle per invalid accept.

Decomposition:
Shared package AHB_package holds:
- ahb_slv_resp_t packed struct {hrdata[DATA_W-1:0], hreadyout, hresp}.
- HTRANS encodings IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
- HRESP_OKAY=1'b0, HRESP_ERROR=1'b1.
- ds_state_e enum {DS_IDLE, DS_ERR1, DS_ERR2}.

One sub-module, ahb_default_slave, holds the FSM, dec_err and err_cnt. The top holds the dsel register and the output mux.

Test Plan:
1. Reset, then hsel=7'b0000100, htrans=NONSEQ, hready_in=1, payload_in[2]={32'hDEADBEEF,1,0} -> next cycle hrdata_out=32'hDEADBEEF, hready_out=1, hresp_out=0.
2. Slave 2 drives hreadyout=0 for 3 cycles while hsel changes to slave 5 -> output tracks slave 2 for all 3 wait cycles; slave 5 is selected only after hready returns to 1.
3. hsel=0, htrans=NONSEQ, accepted -> cycle+1: hready_out=0, hresp_out=1, dec_err=1; cycle+2: hready_out=1, hresp_out=1; err_cnt=1.
4. hsel=7'b0011000 (multi-hot), htrans=SEQ -> same two-cycle ERROR; payload of slaves 3 and 4 is never forwarded.
5. hsel=0, htrans=IDLE -> hready_out=1, hresp_out=0, dec_err=0, err_cnt unchanged.
6. CNT_W=2, 5 back-to-back invalid accepts -> err_cnt reaches 2'b11 and stays there. Then assert HRESETn=0 during DS_ERR1 -> hready_out=1, hresp_out=0, err_cnt=0 immediately.
